// File: rtl/uart_rx_engine_if.sv
`default_nettype none
// ============================================================================
// uart_rx_engine_if : serial pin, frame options and RX FIFO read port
// Revision 1.0
// ============================================================================
interface uart_rx_engine_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    logic                              uart_rx;
    logic [1:0]                        parity_mode;
    logic                              two_stop;
    logic                              rd_en;
    logic                              clear_overrun;
    logic [DATA_BITS-1:0]              rd_data;
    logic                              rd_parity_err;
    logic                              rd_frame_err;
    logic                              rd_break;
    logic                              rd_empty;
    logic [$clog2(FIFO_DEPTH+1)-1:0]   count;
    logic                              overrun;
    logic                              frame_pulse;
    logic                              rx_busy;

    modport master (
        output uart_rx, parity_mode, two_stop, rd_en, clear_overrun,
        input  rd_data, rd_parity_err, rd_frame_err, rd_break, rd_empty,
               count, overrun, frame_pulse, rx_busy
    );

    modport slave (
        input  uart_rx, parity_mode, two_stop, rd_en, clear_overrun,
        output rd_data, rd_parity_err, rd_frame_err, rd_break, rd_empty,
               count, overrun, frame_pulse, rx_busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_engine.sv
`default_nettype none
// ============================================================================
// uart_rx_engine : oversampled UART receiver with error tagging and RX FIFO
// Revision 1.0
// ============================================================================
module uart_rx_engine #(
    parameter int OVER_SAMPLING = 16,
    parameter int DATA_BITS     = 8,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                  sampling_clk,
    input  logic                  rst,
    uart_rx_engine_if.slave       bus_io
);
    localparam int KW = $clog2(OVER_SAMPLING);
    localparam int CW = $clog2(OVER_SAMPLING / 2);
    localparam int IW = $clog2(DATA_BITS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = DATA_BITS + 3;

    localparam logic [KW-1:0] K_LAST    = KW'(OVER_SAMPLING - 1);
    localparam logic [KW-1:0] K_WIN_LO  = KW'(OVER_SAMPLING / 4);
    localparam logic [KW-1:0] K_WIN_HI  = KW'(OVER_SAMPLING / 4 + OVER_SAMPLING / 2 - 2);
    localparam logic [KW-1:0] K_RESOLVE = KW'(OVER_SAMPLING / 4 + OVER_SAMPLING / 2 - 1);
    localparam logic [CW-1:0] C_THRESH  = CW'(OVER_SAMPLING / 4);
    localparam logic [IW-1:0] I_LAST    = IW'(DATA_BITS - 1);
    localparam logic [NW-1:0] N_FULL    = NW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP1     = 3'd4,
        S_STOP2     = 3'd5,
        S_WAIT_HIGH = 3'd6
    } state_t;

    state_t                 state_q;
    logic                   sync1_q, sync2_q, prev_q;
    logic [KW-1:0]          k_q;
    logic [CW-1:0]          cnt_q;
    logic                   bit_q;
    logic [IW-1:0]          bit_idx_q;
    logic [DATA_BITS-1:0]   data_q;
    logic                   par_en_q, odd_q, two_stop_q;
    logic                   par_err_q, frame_err_q, zero_q;
    logic                   busy_q;

    logic                   w_sym_end;
    logic                   w_finish;
    logic [EW-1:0]          w_push_word;

    assign w_sym_end   = (k_q == K_LAST);
    assign w_finish    = w_sym_end && (((state_q == S_STOP1) && !two_stop_q) || (state_q == S_STOP2));
    // Entry fields include the stop bit being resolved in the finishing cycle.
    assign w_push_word = {zero_q & ~bit_q, frame_err_q | ~bit_q, par_err_q, data_q};

    always_ff @(posedge sampling_clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            k_q         <= '0;
            cnt_q       <= '0;
            bit_q       <= 1'b1;
            bit_idx_q   <= '0;
            data_q      <= '0;
            par_en_q    <= 1'b0;
            odd_q       <= 1'b0;
            two_stop_q  <= 1'b0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            sync1_q <= bus_io.uart_rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;

            if (state_q != S_IDLE && state_q != S_WAIT_HIGH) begin
                k_q <= w_sym_end ? '0 : k_q + KW'(1);
                if (w_sym_end)
                    cnt_q <= '0;
                else if (k_q >= K_WIN_LO && k_q <= K_WIN_HI)
                    cnt_q <= cnt_q + CW'(sync2_q);
                if (k_q == K_RESOLVE)
                    bit_q <= (cnt_q >= C_THRESH);
            end

            case (state_q)
                S_IDLE: begin
                    if (prev_q && !sync2_q) begin
                        state_q     <= S_START;
                        busy_q      <= 1'b1;
                        k_q         <= '0;
                        cnt_q       <= '0;
                        bit_idx_q   <= '0;
                        par_en_q    <= (bus_io.parity_mode == 2'b01) || (bus_io.parity_mode == 2'b10);
                        odd_q       <= (bus_io.parity_mode == 2'b10);
                        two_stop_q  <= bus_io.two_stop;
                        par_err_q   <= 1'b0;
                        frame_err_q <= 1'b0;
                        zero_q      <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_sym_end) begin
                        state_q <= bit_q ? S_IDLE : S_DATA;
                        busy_q  <= ~bit_q;
                    end
                end
                S_DATA: begin
                    if (w_sym_end) begin
                        data_q    <= {bit_q, data_q[DATA_BITS-1:1]};
                        zero_q    <= zero_q & ~bit_q;
                        bit_idx_q <= bit_idx_q + IW'(1);
                        if (bit_idx_q == I_LAST)
                            state_q <= par_en_q ? S_PARITY : S_STOP1;
                    end
                end
                S_PARITY: begin
                    if (w_sym_end) begin
                        par_err_q <= ((^data_q) ^ bit_q) != odd_q;
                        zero_q    <= zero_q & ~bit_q;
                        state_q   <= S_STOP1;
                    end
                end
                S_STOP1, S_STOP2: begin
                    if (w_sym_end) begin
                        frame_err_q <= frame_err_q | ~bit_q;
                        zero_q      <= zero_q & ~bit_q;
                        if (w_finish) begin
                            // A low final stop bit means the line may still be in break.
                            state_q <= bit_q ? S_IDLE : S_WAIT_HIGH;
                            busy_q  <= ~bit_q;
                        end else begin
                            state_q <= S_STOP2;
                        end
                    end
                end
                S_WAIT_HIGH: begin
                    if (sync2_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    logic [EW-1:0]  mem_q [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [NW-1:0]  count_q;
    logic           overrun_q, pulse_q;
    logic           w_empty, w_full, w_pop, w_wr, w_drop;
    logic [EW-1:0]  w_head;

    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == N_FULL);
    assign w_pop   = bus_io.rd_en && !w_empty;
    // When full, a simultaneous pop frees the slot the push lands in.
    assign w_wr    = w_finish && (!w_full || w_pop);
    assign w_drop  = w_finish && w_full && !w_pop;
    assign w_head  = mem_q[rd_ptr_q];

    always_ff @(posedge sampling_clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            if (w_wr)
                wr_ptr_q <= wr_ptr_q + PW'(1);
            if (w_pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({w_wr, w_pop})
                2'b10:   count_q <= count_q + NW'(1);
                2'b01:   count_q <= count_q - NW'(1);
                default: count_q <= count_q;
            endcase
            if (w_drop)
                overrun_q <= 1'b1;
            else if (bus_io.clear_overrun)
                overrun_q <= 1'b0;
            pulse_q <= w_wr;
        end
    end

    always_ff @(posedge sampling_clk) begin
        if (w_wr)
            mem_q[wr_ptr_q] <= w_push_word;
    end

    assign bus_io.rd_data       = w_empty ? '0 : w_head[DATA_BITS-1:0];
    assign bus_io.rd_parity_err = !w_empty && w_head[DATA_BITS];
    assign bus_io.rd_frame_err  = !w_empty && w_head[DATA_BITS+1];
    assign bus_io.rd_break      = !w_empty && w_head[DATA_BITS+2];
    assign bus_io.rd_empty      = w_empty;
    assign bus_io.count         = count_q;
    assign bus_io.overrun       = overrun_q;
    assign bus_io.frame_pulse   = pulse_q;
    assign bus_io.rx_busy       = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_engine.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_engine : frame vectors, break/glitch/overrun/reset sequences
// Revision 1.0
// ============================================================================
module tb_uart_rx_engine;
    localparam int OS = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_engine_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if8 ();
    uart_rx_engine_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) if7 ();

    uart_rx_engine #(.OVER_SAMPLING(OS), .DATA_BITS(8), .FIFO_DEPTH(4)) u_dut8 (
        .sampling_clk (clk),
        .rst          (rst),
        .bus_io       (if8.slave)
    );
    uart_rx_engine #(.OVER_SAMPLING(OS), .DATA_BITS(7), .FIFO_DEPTH(4)) u_dut7 (
        .sampling_clk (clk),
        .rst          (rst),
        .bus_io       (if7.slave)
    );

    typedef struct { logic [8:0] data; logic pe; logic fe; logic brk; } exp_t;
    typedef struct {
        int sel; int data; int mode; int ts;
        bit par; bit st1; bit st2;
        bit pe; bit fe; bit brk;
    } vec_t;

    exp_t sb8[$];
    exp_t sb7[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   pulses8 = 0;
    int   pulses7 = 0;
    int   busy_cycles8 = 0;

    always @(negedge clk) begin
        if (if8.frame_pulse) pulses8++;
        if (if7.frame_pulse) pulses7++;
        if (if8.rx_busy)     busy_cycles8++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_line(input int sel, input logic v);
        if (sel == 7) if7.uart_rx = v;
        else          if8.uart_rx = v;
    endtask

    task automatic send_frame(input vec_t v);
        int nb;
        nb = (v.sel == 7) ? 7 : 8;
        if (v.sel == 7) begin
            if7.parity_mode = 2'(v.mode);
            if7.two_stop    = (v.ts != 0);
        end else begin
            if8.parity_mode = 2'(v.mode);
            if8.two_stop    = (v.ts != 0);
        end
        set_line(v.sel, 1'b0);
        repeat (OS) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            set_line(v.sel, ((v.data >> i) & 1) != 0);
            repeat (OS) @(negedge clk);
        end
        if (v.mode == 1 || v.mode == 2) begin
            set_line(v.sel, v.par);
            repeat (OS) @(negedge clk);
        end
        set_line(v.sel, v.st1);
        repeat (OS) @(negedge clk);
        if (v.ts != 0) begin
            set_line(v.sel, v.st2);
            repeat (OS) @(negedge clk);
        end
        set_line(v.sel, 1'b1);
        repeat (OS) @(negedge clk);
    endtask

    task automatic read_head(input int sel, output exp_t h, output logic empty);
        if (sel == 7) begin
            h.data = {2'b00, if7.rd_data};
            h.pe = if7.rd_parity_err; h.fe = if7.rd_frame_err; h.brk = if7.rd_break;
            empty = if7.rd_empty;
        end else begin
            h.data = {1'b0, if8.rd_data};
            h.pe = if8.rd_parity_err; h.fe = if8.rd_frame_err; h.brk = if8.rd_break;
            empty = if8.rd_empty;
        end
    endtask

    task automatic pop_pulse(input int sel);
        if (sel == 7) if7.rd_en = 1'b1; else if8.rd_en = 1'b1;
        @(negedge clk);
        if7.rd_en = 1'b0;
        if8.rd_en = 1'b0;
    endtask

    task automatic wait_nonempty(input int sel, input string tag);
        exp_t h; logic empty;
        for (int c = 0; c < 4 * OS; c++) begin
            read_head(sel, h, empty);
            if (!empty) return;
            @(negedge clk);
        end
        n_tests++; n_fail++;
        $display("FAIL %s timeout: rd_empty still 1 after %0d cycles, expected a frame", tag, 4 * OS);
    endtask

    task automatic drain(input int sel, input string tag);
        exp_t h, e; logic empty; int left;
        for (int g = 0; g < 8; g++) begin
            read_head(sel, h, empty);
            if (empty) break;
            left = (sel == 7) ? sb7.size() : sb8.size();
            if (left == 0) begin
                n_tests++; n_fail++;
                $display("FAIL %s unexpected_entry: got data %0h, expected no entry", tag, h.data);
            end else begin
                if (sel == 7) e = sb7.pop_front(); else e = sb8.pop_front();
                check({tag, " data"},       h.data, e.data);
                check({tag, " parity_err"}, h.pe,   e.pe);
                check({tag, " frame_err"},  h.fe,   e.fe);
                check({tag, " break"},      h.brk,  e.brk);
            end
            pop_pulse(sel);
        end
        check({tag, " missing_entries"}, (sel == 7) ? sb7.size() : sb8.size(), 0);
        read_head(sel, h, empty);
        check({tag, " empty_after"}, empty,  1);
        check({tag, " data_masked"}, h.data, 0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int p0; exp_t e;
        p0 = (v.sel == 7) ? pulses7 : pulses8;
        send_frame(v);
        e.data = 9'(v.data); e.pe = v.pe; e.fe = v.fe; e.brk = v.brk;
        if (v.sel == 7) sb7.push_back(e); else sb8.push_back(e);
        wait_nonempty(v.sel, tag);
        @(negedge clk);
        check({tag, " pulses"}, ((v.sel == 7) ? pulses7 : pulses8) - p0, 1);
        drain(v.sel, tag);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running at time limit, expected $finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[12];
        vec_t v;
        exp_t e;
        int   p0, b0;

        //           sel data  mode ts par st1 st2 pe fe brk
        vecs[0]  = '{8, 'hA5, 0, 0, 0, 1, 1, 0, 0, 0};
        vecs[1]  = '{8, 'h03, 1, 0, 1, 1, 1, 1, 0, 0};
        vecs[2]  = '{8, 'h03, 1, 0, 0, 1, 1, 0, 0, 0};
        vecs[3]  = '{8, 'h5A, 2, 0, 1, 1, 1, 0, 0, 0};
        vecs[4]  = '{8, 'h5A, 2, 0, 0, 1, 1, 1, 0, 0};
        vecs[5]  = '{8, 'hFF, 3, 0, 0, 1, 1, 0, 0, 0};
        vecs[6]  = '{8, 'h81, 0, 0, 0, 0, 1, 0, 1, 0};
        vecs[7]  = '{8, 'h3C, 0, 1, 0, 1, 0, 0, 1, 0};
        vecs[8]  = '{8, 'h00, 1, 0, 0, 0, 1, 0, 1, 1};
        vecs[9]  = '{8, 'h00, 1, 0, 1, 0, 1, 1, 1, 0};
        vecs[10] = '{7, 'h55, 2, 1, 1, 1, 0, 0, 1, 0};
        vecs[11] = '{7, 'h2A, 2, 1, 0, 1, 1, 0, 0, 0};

        if8.uart_rx = 1'b1; if8.parity_mode = 2'b00; if8.two_stop = 1'b0;
        if8.rd_en = 1'b0;   if8.clear_overrun = 1'b0;
        if7.uart_rx = 1'b1; if7.parity_mode = 2'b00; if7.two_stop = 1'b0;
        if7.rd_en = 1'b0;   if7.clear_overrun = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("reset rd_empty",    if8.rd_empty,    1);
        check("reset count",       if8.count,       0);
        check("reset overrun",     if8.overrun,     0);
        check("reset frame_pulse", if8.frame_pulse, 0);
        check("reset rx_busy",     if8.rx_busy,     0);
        check("reset rd_data",     if8.rd_data,     0);

        for (int i = 0; i < 12; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Short low glitch: start rejected, nothing pushed.
        p0 = pulses8; b0 = busy_cycles8;
        set_line(8, 1'b0);
        repeat (3) @(negedge clk);
        set_line(8, 1'b1);
        repeat (2 * OS) @(negedge clk);
        check("glitch busy_seen", (busy_cycles8 - b0) > 0, 1);
        check("glitch rx_busy",   if8.rx_busy, 0);
        check("glitch count",     if8.count,   0);
        check("glitch pulses",    pulses8 - p0, 0);

        // Line held low for 20 bit times: one break entry, no retrigger.
        p0 = pulses8;
        if8.parity_mode = 2'b00; if8.two_stop = 1'b0;
        set_line(8, 1'b0);
        repeat (20 * OS) @(negedge clk);
        check("break count_during", if8.count,   1);
        check("break busy_during",  if8.rx_busy, 1);
        set_line(8, 1'b1);
        repeat (2 * OS) @(negedge clk);
        check("break busy_after", if8.rx_busy, 0);
        check("break pulses",     pulses8 - p0, 1);
        e = '{9'h000, 1'b0, 1'b1, 1'b1};
        sb8.push_back(e);
        drain(8, "break");
        v = '{8, 'h5A, 0, 0, 0, 1, 1, 0, 0, 0};
        run_vec(v, "after_break");

        // Five frames into a 4-deep FIFO with no reads.
        p0 = pulses8;
        for (int i = 0; i < 5; i++) begin
            v = '{8, 'h11 * (i + 1), 0, 0, 0, 1, 1, 0, 0, 0};
            send_frame(v);
            if (i < 4) begin
                e = '{9'(v.data), 1'b0, 1'b0, 1'b0};
                sb8.push_back(e);
            end
        end
        check("ovr count",   if8.count,    4);
        check("ovr overrun", if8.overrun,  1);
        check("ovr pulses",  pulses8 - p0, 4);
        drain(8, "ovr");
        check("ovr sticky", if8.overrun, 1);
        if8.clear_overrun = 1'b1;
        @(negedge clk);
        if8.clear_overrun = 1'b0;
        check("ovr cleared", if8.overrun, 0);

        // Reset mid-frame with one entry already queued.
        v = '{8, 'h77, 0, 0, 0, 1, 1, 0, 0, 0};
        send_frame(v);
        check("rstmid count_before", if8.count, 1);
        set_line(8, 1'b0);
        repeat (3 * OS) @(negedge clk);
        check("rstmid busy_before", if8.rx_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid rd_empty", if8.rd_empty, 1);
        check("rstmid count",    if8.count,    0);
        check("rstmid rx_busy",  if8.rx_busy,  0);
        set_line(8, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (OS) @(negedge clk);
        check("rstmid count_after", if8.count, 0);
        v = '{8, 'hC3, 0, 0, 0, 1, 1, 0, 0, 0};
        run_vec(v, "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
